// File: rtl/multicycle_controller_pkg.sv
// Shared encodings for the multicycle RV32I control path: opcodes, datapath
// select codes, ALU control codes and the controller state type.
package multicycle_controller_pkg;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_RDATA  = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECR,
    S_EXECI,
    S_ALUWB,
    S_BRANCH,
    S_JAL,
    S_TRAP
  } state_t;

  function automatic logic [1:0] imm_src_for(input logic [6:0] op);
    case (op)
      OP_SW:   return IMM_S;
      OP_BR:   return IMM_B;
      OP_JAL:  return IMM_J;
      default: return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_controller_alu_decoder.sv
// Combinational ALU control decode from the FSM's alu_op and instruction funct fields.
module alu_decoder
  import multicycle_controller_pkg::*;
(
  input  logic [1:0] i_alu_op,
  input  logic [2:0] i_funct3,
  input  logic       i_funct7_5,
  input  logic       i_op5,
  output logic [2:0] o_alu_control
);

  always_comb begin
    o_alu_control = ALU_ADD;
    case (i_alu_op)
      ALUOP_SUB: o_alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (i_funct3)
          // op[5] separates R-type (sub possible) from I-type (addi only)
          3'b000:  o_alu_control = (i_op5 && i_funct7_5) ? ALU_SUB : ALU_ADD;
          3'b010:  o_alu_control = ALU_SLT;
          3'b110:  o_alu_control = ALU_OR;
          3'b111:  o_alu_control = ALU_AND;
          default: o_alu_control = ALU_ADD;
        endcase
      end
      default: o_alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Main control FSM of the multicycle RV32I core: sequences fetch, decode,
// execute, memory and writeback, and drives datapath selects and strobes.
module multicycle_controller
  import multicycle_controller_pkg::*;
#(
  parameter bit RESET_TRAP_CLEAR = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  input  logic       zero,
  input  logic       mem_ack,
  output logic       mem_req,
  output logic       adr_src,
  output logic       mem_write,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic [1:0] imm_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] result_src,
  output logic [2:0] alu_control,
  output logic       illegal
);

  state_t     r_state;
  state_t     w_next;
  logic       w_req, w_adr, w_mw, w_irw, w_pc_update, w_branch, w_rw, w_ill, w_taken;
  logic [1:0] w_src_a, w_src_b, w_res, w_alu_op;
  logic [2:0] w_alu_control;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= (!RESET_TRAP_CLEAR && r_state == S_TRAP) ? S_TRAP : S_FETCH;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next      = r_state;
    w_req       = 1'b0;
    w_adr       = 1'b0;
    w_mw        = 1'b0;
    w_irw       = 1'b0;
    w_pc_update = 1'b0;
    w_branch    = 1'b0;
    w_rw        = 1'b0;
    w_ill       = 1'b0;
    w_src_a     = SRCA_PC;
    w_src_b     = SRCB_RS2;
    w_res       = RES_ALUOUT;
    w_alu_op    = ALUOP_ADD;
    case (r_state)
      S_FETCH: begin
        w_req   = 1'b1;
        w_src_b = SRCB_FOUR;
        w_res   = RES_ALURES;
        if (mem_ack) begin
          w_irw       = 1'b1;
          w_pc_update = 1'b1;
          w_next      = S_DECODE;
        end
      end
      S_DECODE: begin
        w_src_a = SRCA_OLDPC;
        w_src_b = SRCB_IMM;
        case (op)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_R:         w_next = S_EXECR;
          OP_I:         w_next = S_EXECI;
          OP_BR:        w_next = S_BRANCH;
          OP_JAL:       w_next = S_JAL;
          default:      w_next = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        w_src_a = SRCA_RS1;
        w_src_b = SRCB_IMM;
        w_next  = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        w_req = 1'b1;
        w_adr = 1'b1;
        if (mem_ack) w_next = S_MEMWB;
      end
      S_MEMWB: begin
        w_res  = RES_RDATA;
        w_rw   = 1'b1;
        w_next = S_FETCH;
      end
      S_MEMWRITE: begin
        w_req = 1'b1;
        w_adr = 1'b1;
        w_mw  = 1'b1;
        if (mem_ack) w_next = S_FETCH;
      end
      S_EXECR: begin
        w_src_a  = SRCA_RS1;
        w_alu_op = ALUOP_FUNCT;
        w_next   = S_ALUWB;
      end
      S_EXECI: begin
        w_src_a  = SRCA_RS1;
        w_src_b  = SRCB_IMM;
        w_alu_op = ALUOP_FUNCT;
        w_next   = S_ALUWB;
      end
      S_ALUWB: begin
        w_rw   = 1'b1;
        w_next = S_FETCH;
      end
      S_BRANCH: begin
        w_src_a  = SRCA_RS1;
        w_alu_op = ALUOP_SUB;
        w_branch = 1'b1;
        w_next   = S_FETCH;
      end
      S_JAL: begin
        w_src_a     = SRCA_OLDPC;
        w_src_b     = SRCB_FOUR;
        w_pc_update = 1'b1;
        w_next      = S_ALUWB;
      end
      S_TRAP:  w_ill = 1'b1;
      default: w_next = S_FETCH;
    endcase
  end

  always_comb begin
    case (funct3)
      3'b000:  w_taken = zero;
      3'b001:  w_taken = ~zero;
      default: w_taken = 1'b0;
    endcase
  end

  alu_decoder u_alu_decoder (
    .i_alu_op      (w_alu_op),
    .i_funct3      (funct3),
    .i_funct7_5    (funct7_5),
    .i_op5         (op[5]),
    .o_alu_control (w_alu_control)
  );

  // Everything is forced low during reset so an aborted access emits no strobe.
  assign mem_req     = w_req & ~rst;
  assign adr_src     = w_adr & ~rst;
  assign mem_write   = w_mw & ~rst;
  assign ir_write    = w_irw & ~rst;
  assign pc_write    = (w_pc_update | (w_branch & w_taken)) & ~rst;
  assign reg_write   = w_rw & ~rst;
  assign illegal     = w_ill & ~rst;
  assign imm_src     = rst ? '0 : imm_src_for(op);
  assign alu_src_a   = rst ? '0 : w_src_a;
  assign alu_src_b   = rst ? '0 : w_src_b;
  assign result_src  = rst ? '0 : w_res;
  assign alu_control = rst ? '0 : w_alu_control;

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: instruction-level model predicts
// the timed sequence of control events; a monitor compares every observed event.
module tb_multicycle_controller;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7_5, zero, mem_ack;
  logic       mem_req, adr_src, mem_write, ir_write, pc_write, reg_write, illegal;
  logic [1:0] imm_src, alu_src_a, alu_src_b, result_src;
  logic [2:0] alu_control;

  multicycle_controller #(.RESET_TRAP_CLEAR(1'b1)) dut (
    .clk         (clk),
    .rst         (rst),
    .op          (op),
    .funct3      (funct3),
    .funct7_5    (funct7_5),
    .zero        (zero),
    .mem_ack     (mem_ack),
    .mem_req     (mem_req),
    .adr_src     (adr_src),
    .mem_write   (mem_write),
    .ir_write    (ir_write),
    .pc_write    (pc_write),
    .reg_write   (reg_write),
    .imm_src     (imm_src),
    .alu_src_a   (alu_src_a),
    .alu_src_b   (alu_src_b),
    .result_src  (result_src),
    .alu_control (alu_control),
    .illegal     (illegal)
  );

  always #5 clk = ~clk;

  // strb = {illegal, mem_req, adr_src, mem_write, ir_write, pc_write, reg_write}
  typedef struct packed {
    int unsigned cyc;
    logic [6:0]  strb;
    logic [1:0]  a;
    logic [1:0]  b;
    logic [1:0]  rs;
    logic [2:0]  alu;
  } ev_t;

  ev_t         exp_q[$];
  ev_t         m_got, m_exp;
  int unsigned cyc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic ev_t mk(input int unsigned c, input logic [6:0] s, input logic [1:0] a,
                             input logic [1:0] b, input logic [1:0] rs, input logic [2:0] alu);
    ev_t e;
    e.cyc = c; e.strb = s; e.a = a; e.b = b; e.rs = rs; e.alu = alu;
    return e;
  endfunction

  function automatic logic [2:0] alu_fn(input logic [2:0] f3, input logic f75, input logic is_r);
    case (f3)
      3'b000:  return (is_r && f75) ? 3'b001 : 3'b000;
      3'b010:  return 3'b101;
      3'b110:  return 3'b011;
      3'b111:  return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic [1:0] imm_exp(input logic [6:0] o);
    if (o == OP_SW) return 2'b01;
    if (o == OP_BR) return 2'b10;
    if (o == OP_JAL) return 2'b11;
    return 2'b00;
  endfunction

  function automatic bit is_legal(input logic [6:0] o);
    return o == OP_LW || o == OP_SW || o == OP_R || o == OP_I || o == OP_BR || o == OP_JAL;
  endfunction

  // Monitor: any cycle with a strobe, an rs1 ALU operation or illegal is an event.
  always @(negedge clk) begin
    if (!rst && (mem_req || mem_write || ir_write || pc_write || reg_write || illegal ||
                 alu_src_a == 2'b10)) begin
      m_got = mk(cyc, {illegal, mem_req, adr_src, mem_write, ir_write, pc_write, reg_write},
                 alu_src_a, alu_src_b, result_src, alu_control);
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_event cyc=%0d got=%h required=none", cyc, m_got);
      end else begin
        m_exp = exp_q.pop_front();
        if (m_got !== m_exp) begin
          n_bad++;
          $display("FAIL event cyc=%0d got=%h required=%h", cyc, m_got, m_exp);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
    n_cmp++;
    if (got !== req) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%h required=%h", name, cyc, got, req);
    end
  endtask

  // ackp entries: 0 = ack low, 1 = ack high, 2 = random (state ignores ack)
  task automatic drive(input int ackp[$], input int unsigned dec_c, input logic [6:0] o);
    foreach (ackp[i]) begin
      mem_ack = (ackp[i] == 2) ? 1'($urandom_range(0, 1)) : (ackp[i] == 1);
      if (cyc == dec_c) begin
        @(negedge clk);
        chk("imm_src_decode", 32'(imm_src), 32'(imm_exp(o)));
      end
      tick();
    end
  endtask

  task automatic fetch_decode(inout int unsigned t, inout int ackp[$], input int unsigned wf,
                              output int unsigned dec_c);
    for (int unsigned i = 0; i < wf; i++) begin
      exp_q.push_back(mk(t, 7'b0100000, 2'b00, 2'b10, 2'b10, 3'b000));
      t++; ackp.push_back(0);
    end
    exp_q.push_back(mk(t, 7'b0100110, 2'b00, 2'b10, 2'b10, 3'b000));
    t++; ackp.push_back(1);
    dec_c = t;
    t++; ackp.push_back(2);
  endtask

  task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f75,
                           input logic z, input int unsigned wf, input int unsigned wd);
    int unsigned t, dec_c;
    int          ackp[$];
    logic        tk;
    t = cyc;
    op = o; funct3 = f3; funct7_5 = f75; zero = z;
    tk = (f3 == 3'b000) ? z : (f3 == 3'b001) ? !z : 1'b0;
    fetch_decode(t, ackp, wf, dec_c);
    case (o)
      OP_R, OP_I: begin
        exp_q.push_back(mk(t, 7'b0, 2'b10, (o == OP_R) ? 2'b00 : 2'b01, 2'b00,
                           alu_fn(f3, f75, o == OP_R)));
        t++; ackp.push_back(2);
        exp_q.push_back(mk(t, 7'b0000001, 2'b00, 2'b00, 2'b00, 3'b000));
        t++; ackp.push_back(2);
      end
      OP_LW, OP_SW: begin
        exp_q.push_back(mk(t, 7'b0, 2'b10, 2'b01, 2'b00, 3'b000));
        t++; ackp.push_back(2);
        for (int unsigned i = 0; i <= wd; i++) begin
          exp_q.push_back(mk(t, (o == OP_LW) ? 7'b0110000 : 7'b0111000,
                             2'b00, 2'b00, 2'b00, 3'b000));
          t++; ackp.push_back((i == wd) ? 1 : 0);
        end
        if (o == OP_LW) begin
          exp_q.push_back(mk(t, 7'b0000001, 2'b00, 2'b00, 2'b01, 3'b000));
          t++; ackp.push_back(2);
        end
      end
      OP_BR: begin
        exp_q.push_back(mk(t, {5'b0, tk, 1'b0}, 2'b10, 2'b00, 2'b00, 3'b001));
        t++; ackp.push_back(2);
      end
      default: begin
        exp_q.push_back(mk(t, 7'b0000010, 2'b01, 2'b10, 2'b00, 3'b000));
        t++; ackp.push_back(2);
        exp_q.push_back(mk(t, 7'b0000001, 2'b00, 2'b00, 2'b00, 3'b000));
        t++; ackp.push_back(2);
      end
    endcase
    drive(ackp, dec_c, o);
  endtask

  task automatic rst_pulse_and_resume(input string name);
    rst = 1'b1;
    @(negedge clk);
    chk({name, "_strobes"}, 32'({mem_req, mem_write, ir_write, pc_write, reg_write, illegal}), 0);
    chk({name, "_selects"}, 32'({adr_src, imm_src, alu_src_a, alu_src_b, result_src,
                                 alu_control}), 0);
    tick();
    rst = 1'b0;
    #1;
    chk({name, "_fetch"}, 32'({mem_req, adr_src, illegal}), 32'(3'b100));
  endtask

  task automatic run_trap(input logic [6:0] o, input int unsigned wf, input int unsigned n);
    int unsigned t, dec_c;
    int          ackp[$];
    t = cyc;
    op = o; funct3 = 3'($urandom); funct7_5 = 1'($urandom); zero = 1'($urandom);
    fetch_decode(t, ackp, wf, dec_c);
    for (int unsigned i = 0; i < n; i++) begin
      exp_q.push_back(mk(t, 7'b1000000, 2'b00, 2'b00, 2'b00, 3'b000));
      t++; ackp.push_back(2);
    end
    drive(ackp, dec_c, o);
    rst_pulse_and_resume("trap_rst");
  endtask

  task automatic run_sw_abort(input int unsigned wf, input int unsigned wab);
    int unsigned t, dec_c;
    int          ackp[$];
    t = cyc;
    op = OP_SW; funct3 = 3'b010; funct7_5 = 1'b0; zero = 1'b0;
    fetch_decode(t, ackp, wf, dec_c);
    exp_q.push_back(mk(t, 7'b0, 2'b10, 2'b01, 2'b00, 3'b000));
    t++; ackp.push_back(2);
    for (int unsigned i = 0; i < wab; i++) begin
      exp_q.push_back(mk(t, 7'b0111000, 2'b00, 2'b00, 2'b00, 3'b000));
      t++; ackp.push_back(0);
    end
    drive(ackp, dec_c, OP_SW);
    mem_ack = 1'b0;
    #2;
    chk("sw_wait_mem_write", 32'(mem_write), 1);
    rst = 1'b1;
    #1;
    chk("abort_strobes", 32'({mem_req, mem_write, ir_write, pc_write, reg_write}), 0);
    tick();
    rst = 1'b0;
    #1;
    chk("abort_resume_fetch", 32'({mem_req, adr_src}), 32'(2'b10));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog cyc=%0d got=timeout required=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0] bad_op;
    rst = 1'b1; op = '0; funct3 = '0; funct7_5 = 1'b0; zero = 1'b0; mem_ack = 1'b0;
    tick();
    tick();
    @(negedge clk);
    chk("reset_strobes", 32'({mem_req, mem_write, ir_write, pc_write, reg_write, illegal}), 0);
    chk("reset_selects", 32'({adr_src, alu_src_a, alu_src_b, result_src, alu_control}), 0);
    tick();
    rst = 1'b0;
    #1;
    chk("reset_fetch", 32'({mem_req, adr_src}), 32'(2'b10));

    run_instr(OP_R,   3'b000, 1'b1, 1'b0, 0, 0);
    run_instr(OP_LW,  3'b010, 1'b0, 1'b0, 0, 3);
    run_instr(OP_BR,  3'b000, 1'b0, 1'b1, 0, 0);
    run_instr(OP_BR,  3'b000, 1'b0, 1'b0, 0, 0);
    run_instr(OP_BR,  3'b001, 1'b0, 1'b1, 0, 0);
    run_instr(OP_JAL, 3'b000, 1'b0, 1'b0, 0, 0);
    run_instr(OP_I,   3'b000, 1'b1, 1'b0, 1, 0);
    run_instr(OP_SW,  3'b010, 1'b0, 1'b0, 2, 2);
    run_trap(7'b1111111, 0, 20);
    run_sw_abort(0, 2);

    for (int n = 0; n < 120; n++) begin
      case ($urandom_range(0, 11))
        0, 1: run_instr(OP_R, 3'($urandom), 1'($urandom), 1'($urandom),
                        $urandom_range(0, 2), 0);
        2, 3: run_instr(OP_I, 3'($urandom), 1'($urandom), 1'($urandom),
                        $urandom_range(0, 2), 0);
        4, 5: run_instr(OP_LW, 3'($urandom), 1'($urandom), 1'($urandom),
                        $urandom_range(0, 2), $urandom_range(0, 3));
        6:    run_instr(OP_SW, 3'($urandom), 1'($urandom), 1'($urandom),
                        $urandom_range(0, 2), $urandom_range(0, 3));
        7, 8: run_instr(OP_BR, 3'($urandom_range(0, 2)), 1'($urandom), 1'($urandom),
                        $urandom_range(0, 2), 0);
        9:    run_instr(OP_JAL, 3'($urandom), 1'($urandom), 1'($urandom),
                        $urandom_range(0, 2), 0);
        10: begin
          bad_op = 7'($urandom);
          while (is_legal(bad_op)) bad_op = 7'($urandom);
          run_trap(bad_op, $urandom_range(0, 2), $urandom_range(1, 4));
        end
        default: run_sw_abort($urandom_range(0, 1), $urandom_range(1, 3));
      endcase
    end

    rst = 1'b1;
    tick();
    tick();
    chk("scoreboard_drained", 32'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
